// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one fixed-latency single-port memory between the I-cache and D-cache miss paths.
// Serves I/D line fills and D-side single-word write-through, returning fill words as rvalid pulses.
module mem_port_arbiter #(
    parameter int MEM_LATENCY = 2,
    parameter int LINE_WORDS  = 4,
    parameter int IDX_W       = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_req,
    input  logic [15:0]      i_addr,
    output logic [15:0]      i_rdata,
    output logic             i_rvalid,
    output logic             i_done,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [15:0]      d_addr,
    input  logic [15:0]      d_wdata,
    output logic [15:0]      d_rdata,
    output logic             d_rvalid,
    output logic             d_done,
    output logic [IDX_W-1:0] word_idx,
    output logic             mem_readM,
    output logic             mem_writeM,
    output logic [15:0]      mem_address,
    inout  wire  [15:0]      mem_data
);

    localparam int CYC_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(MEM_LATENCY - 1);
    localparam logic [IDX_W-1:0] WORD_LAST = IDX_W'(LINE_WORDS - 1);
    localparam logic [15:0]      LINE_MASK = ~16'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t            state_q;
    logic              last_d_q;
    logic              side_d_q;
    logic              we_q;
    logic [15:0]       wdata_q;
    logic [CYC_W-1:0]  cyc_q;
    logic [IDX_W-1:0]  word_q;
    logic [15:0]       i_rdata_q;
    logic [15:0]       d_rdata_q;
    logic              i_rvalid_q;
    logic              d_rvalid_q;
    logic              i_done_q;
    logic              d_done_q;
    logic [IDX_W-1:0]  word_idx_q;
    logic              rd_q;
    logic              wr_q;
    logic [15:0]       addr_q;
    logic              grant_d;

    // Handshake: a requester raises req (level) with stable inputs and holds it until its
    // done pulse; inputs are latched at grant, and req must be low by the edge after done.
    // Under contention the side that did not win last time is granted.
    assign grant_d = d_req && (!i_req || !last_d_q);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            last_d_q   <= 1'b0;
            side_d_q   <= 1'b0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            cyc_q      <= '0;
            word_q     <= '0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            i_done_q   <= 1'b0;
            d_done_q   <= 1'b0;
            word_idx_q <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
        end else begin
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            i_done_q   <= 1'b0;
            d_done_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_req || d_req) begin
                        side_d_q <= grant_d;
                        last_d_q <= grant_d;
                        we_q     <= grant_d && d_we;
                        wdata_q  <= d_wdata;
                        cyc_q    <= '0;
                        word_q   <= '0;
                        state_q  <= BUSY;
                        if (grant_d && d_we) begin
                            wr_q   <= 1'b1;
                            addr_q <= d_addr;
                        end else begin
                            rd_q   <= 1'b1;
                            addr_q <= (grant_d ? d_addr : i_addr) & LINE_MASK;
                        end
                    end
                end
                BUSY: begin
                    if (cyc_q == CYC_LAST) begin
                        cyc_q <= '0;
                        if (we_q) begin
                            wr_q     <= 1'b0;
                            d_done_q <= 1'b1;
                            state_q  <= RESP;
                        end else begin
                            // Memory data is valid in the last cycle an address is held.
                            if (side_d_q) begin
                                d_rdata_q  <= mem_data;
                                d_rvalid_q <= 1'b1;
                            end else begin
                                i_rdata_q  <= mem_data;
                                i_rvalid_q <= 1'b1;
                            end
                            word_idx_q <= word_q;
                            if (word_q == WORD_LAST) begin
                                rd_q    <= 1'b0;
                                state_q <= RESP;
                                if (side_d_q) begin
                                    d_done_q <= 1'b1;
                                end else begin
                                    i_done_q <= 1'b1;
                                end
                            end else begin
                                word_q <= word_q + IDX_W'(1);
                                addr_q <= addr_q + 16'd1;
                            end
                        end
                    end else begin
                        cyc_q <= cyc_q + CYC_W'(1);
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign i_rdata     = i_rdata_q;
    assign d_rdata     = d_rdata_q;
    assign i_rvalid    = i_rvalid_q;
    assign d_rvalid    = d_rvalid_q;
    assign i_done      = i_done_q;
    assign d_done      = d_done_q;
    assign word_idx    = word_idx_q;
    assign mem_readM   = rd_q;
    assign mem_writeM  = wr_q;
    assign mem_address = addr_q;
    assign mem_data    = wr_q ? wdata_q : 'z;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a transaction-level model predicts per-cycle bus activity and
// response pulses into queues; a negedge monitor pops and compares against the DUT.
module tb_mem_port_arbiter;

    localparam int ML = 2;
    localparam int LW = 4;
    localparam int IW = 2;
    localparam logic [15:0] IDLE_PAT = 16'h5A5A;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          i_req = 1'b0;
    logic [15:0]   i_addr = '0;
    logic [15:0]   i_rdata;
    logic          i_rvalid;
    logic          i_done;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [15:0]   d_addr = '0;
    logic [15:0]   d_wdata = '0;
    logic [15:0]   d_rdata;
    logic          d_rvalid;
    logic          d_done;
    logic [IW-1:0] word_idx;
    logic          mem_readM;
    logic          mem_writeM;
    logic [15:0]   mem_address;
    wire  [15:0]   mem_data;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_LATENCY(ML), .LINE_WORDS(LW), .IDX_W(IW)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_done(d_done),
        .word_idx(word_idx), .mem_readM(mem_readM), .mem_writeM(mem_writeM),
        .mem_address(mem_address), .mem_data(mem_data)
    );

    function automatic logic [15:0] memfn(input logic [15:0] a);
        return (a * 16'h9E37) ^ 16'h1234;
    endfunction

    // Memory model: correct data only in the last cycle an address has been held.
    logic [15:0] prev_addr = '0;
    logic        prev_rd = 1'b0;
    int          held_q = 0;
    int          held_now;
    assign held_now = (mem_readM && prev_rd && mem_address == prev_addr) ? held_q + 1 : 0;
    always @(posedge clk) begin
        prev_addr <= mem_address;
        prev_rd   <= mem_readM;
        held_q    <= held_now;
    end
    assign mem_data = mem_writeM ? 16'hzzzz :
                      (mem_readM ? ((held_now == ML - 1) ? memfn(mem_address) : ~memfn(mem_address))
                                 : IDLE_PAT);

    typedef struct {
        int          cyc;
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
    } bus_t;

    typedef struct {
        int          cyc;
        logic        i_rv;
        logic        d_rv;
        logic        i_dn;
        logic        d_dn;
        logic [IW-1:0] idx;
        logic [15:0] data;
    } resp_t;

    bus_t  bus_q[$];
    resp_t exp_q[$];

    int          checks = 0;
    int          errors = 0;
    int          cyc_n = 0;
    int          next_edge = 0;
    bit          model_on = 1'b0;
    logic        last_d = 1'b0;
    logic [15:0] i_last = '0;
    logic [15:0] d_last = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc_n, act, exp);
        end
    endtask

    task automatic model_grant();
        logic        gd;
        int          t0;
        logic [15:0] a;
        logic [15:0] base;
        bus_t        b;
        resp_t       r;
        gd = d_req && (!i_req || !last_d);
        last_d = gd;
        t0 = cyc_n;
        if (gd && d_we) begin
            for (int j = 0; j < ML; j++) begin
                b.cyc = t0 + j; b.rd = 1'b0; b.wr = 1'b1; b.addr = d_addr; b.data = d_wdata;
                bus_q.push_back(b);
            end
            r.cyc = t0 + ML; r.i_rv = 1'b0; r.d_rv = 1'b0; r.i_dn = 1'b0; r.d_dn = 1'b1;
            r.idx = '0; r.data = '0;
            exp_q.push_back(r);
            next_edge = t0 + ML + 2;
        end else begin
            a = gd ? d_addr : i_addr;
            base = a - (a % LW);
            for (int k = 0; k < LW; k++) begin
                for (int j = 0; j < ML; j++) begin
                    b.cyc = t0 + k * ML + j; b.rd = 1'b1; b.wr = 1'b0;
                    b.addr = 16'(base + k); b.data = '0;
                    bus_q.push_back(b);
                end
                r.cyc = t0 + (k + 1) * ML;
                r.i_rv = !gd; r.d_rv = gd;
                r.i_dn = (k == LW - 1) && !gd; r.d_dn = (k == LW - 1) && gd;
                r.idx = IW'(k); r.data = memfn(16'(base + k));
                exp_q.push_back(r);
            end
            next_edge = t0 + LW * ML + 2;
        end
    endtask

    always @(posedge clk) begin
        cyc_n++;
        if (!reset_n) begin
            model_on = 1'b1;
            bus_q.delete();
            exp_q.delete();
            last_d = 1'b0;
            i_last = '0;
            d_last = '0;
            next_edge = cyc_n + 1;
        end else if (model_on && cyc_n >= next_edge && (i_req || d_req)) begin
            model_grant();
        end
    end

    always @(negedge clk) begin : monitor
        bus_t  eb;
        resp_t er;
        if (model_on) begin
            if (bus_q.size() > 0 && bus_q[0].cyc == cyc_n) begin
                eb = bus_q.pop_front();
                check("readM", 32'(mem_readM), 32'(eb.rd));
                check("writeM", 32'(mem_writeM), 32'(eb.wr));
                check("address", 32'(mem_address), 32'(eb.addr));
                if (eb.wr) check("wdata", 32'(mem_data), 32'(eb.data));
            end else begin
                check("strobes_idle", 32'({mem_readM, mem_writeM}), 32'd0);
                check("mem_data_released", 32'(mem_data), 32'(IDLE_PAT));
            end
            er.cyc = cyc_n; er.i_rv = 1'b0; er.d_rv = 1'b0; er.i_dn = 1'b0; er.d_dn = 1'b0;
            er.idx = '0; er.data = '0;
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc_n) er = exp_q.pop_front();
            check("pulses", 32'({i_rvalid, d_rvalid, i_done, d_done}),
                  32'({er.i_rv, er.d_rv, er.i_dn, er.d_dn}));
            if (er.i_rv || er.d_rv) check("word_idx", 32'(word_idx), 32'(er.idx));
            if (er.i_rv) i_last = er.data;
            if (er.d_rv) d_last = er.data;
            check("i_rdata", 32'(i_rdata), 32'(i_last));
            check("d_rdata", 32'(d_rdata), 32'(d_last));
        end
    end

    task automatic i_txn(input logic [15:0] a);
        int n;
        i_req = 1'b1;
        i_addr = a;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!i_done && n < 300);
        checks++;
        if (!i_done) begin
            errors++;
            $display("FAIL i_txn_timeout addr %h: got no i_done, expected one within 300 cycles", a);
        end
        @(posedge clk);
        #1 i_req = 1'b0;
        i_addr = 16'($urandom);
    endtask

    task automatic d_txn(input logic we, input logic [15:0] a, input logic [15:0] wd);
        int n;
        d_req = 1'b1;
        d_we = we;
        d_addr = a;
        d_wdata = wd;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!d_done && n < 300);
        checks++;
        if (!d_done) begin
            errors++;
            $display("FAIL d_txn_timeout addr %h: got no d_done, expected one within 300 cycles", a);
        end
        @(posedge clk);
        #1 d_req = 1'b0;
        d_we = 1'($urandom);
        d_addr = 16'($urandom);
        d_wdata = 16'($urandom);
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state();
        check("rst_i_rdata", 32'(i_rdata), 32'd0);
        check("rst_i_rvalid", 32'(i_rvalid), 32'd0);
        check("rst_i_done", 32'(i_done), 32'd0);
        check("rst_d_rdata", 32'(d_rdata), 32'd0);
        check("rst_d_rvalid", 32'(d_rvalid), 32'd0);
        check("rst_d_done", 32'(d_done), 32'd0);
        check("rst_word_idx", 32'(word_idx), 32'd0);
        check("rst_readM", 32'(mem_readM), 32'd0);
        check("rst_writeM", 32'(mem_writeM), 32'd0);
        check("rst_address", 32'(mem_address), 32'd0);
        check("rst_mem_data", 32'(mem_data), 32'(IDLE_PAT));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_state();
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_state();
        @(posedge clk);
        #1 reset_n = 1'b1;
        gap(1);

        // Single I line fill, then a D write-through.
        i_txn(16'h0013);
        gap(2);
        d_txn(1'b1, 16'h0025, 16'hBEEF);
        gap(2);

        // Simultaneous requests right after reset.
        do_reset();
        fork
            i_txn(16'h0140);
            d_txn(1'b0, 16'h0236, 16'h0000);
        join
        gap(2);

        // D arrives mid I-burst; I re-raises immediately after its done.
        fork
            begin
                i_txn(16'h0301);
                i_txn(16'h0305);
            end
            begin
                repeat (3) @(posedge clk);
                #1 d_txn(1'b0, 16'h0402, 16'h0000);
            end
        join
        gap(3);

        // Reset during word 2 of a D read, then a fresh I fill.
        d_req = 1'b1;
        d_we = 1'b0;
        d_addr = 16'h0A1B;
        repeat (5) @(posedge clk);
        #1 reset_n = 1'b0;
        d_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_state();
        @(posedge clk);
        #1 reset_n = 1'b1;
        gap(1);
        i_txn(16'h0777);
        gap(2);

        // I request dropped mid-burst still completes once.
        i_req = 1'b1;
        i_addr = 16'h0550;
        repeat (3) @(posedge clk);
        #1 i_req = 1'b0;
        gap(15);

        // Randomized contention between both sides.
        fork
            begin
                repeat (40) begin
                    gap($urandom_range(0, 3));
                    i_txn(16'($urandom));
                end
            end
            begin
                repeat (40) begin
                    gap($urandom_range(0, 3));
                    d_txn(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
                end
            end
        join

        gap(20);
        check("drain", 32'(bus_q.size() + exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
